pwm_compare_deadtime: RTL and testbench
=======================================

Name: pwm_compare_deadtime

Overview:
- Downstream consumer of the 8-to-1 compare-value mux in the PWM datapath.
- Takes the selected 16-bit compare value and the running carrier count.
- Holds the compare value in a shadow/active register pair, with a programmable load event.
- Produces complementary high/low gate signals, with separate rising-edge and falling-edge dead-time insertion.

Parameters:
- COUNT_WIDTH, 16: width of carrier and compare values; matches the PWM count width.
- DT_WIDTH, 8: width of the dead-time counters.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  channel enable
- cmp_in  input  COUNT_WIDTH  compare value from the mux output
- carrier  input  COUNT_WIDTH  current carrier counter value
- carrier_zero  input  1  one-cycle pulse when the carrier is at zero
- carrier_top  input  1  one-cycle pulse when the carrier is at period/top
- load_mode  input  2  compare update event: 00 immediate, 01 at zero, 10 at top, 11 at zero or top
- dt_rise  input  DT_WIDTH  dead time before pwm_h asserts, in clk cycles
- dt_fall  input  DT_WIDTH  dead time before pwm_l asserts, in clk cycles
- pwm_h  output  1  high-side gate, registered
- pwm_l  output  1  low-side gate, registered
- cmp_active  output  COUNT_WIDTH  compare value currently in use
- load_ack  output  1  one-cycle pulse, high in the cycle after cmp_active was updated

Behaviour:
- Reset: clk and rst_n as named above; reset is asynchronous and active-low.
  - Reset values: pwm_h=0, pwm_l=0, cmp_active=0, load_ack=0, raw_q=0, state=IDLE, dead counter=0.
- Compare loading: cmp_active <= cmp_in on a clock edge where the load event is true.
  - 00: every cycle.
  - 01: carrier_zero=1.
  - 10: carrier_top=1.
  - 11: carrier_zero OR carrier_top; a simultaneous zero and top pulse gives a single load.
  - load_ack=1 in the cycle following each load, otherwise 0. Mode 00 therefore holds load_ack=1 continuously.
  - Loading is independent of en.
- Raw compare: raw_q <= (carrier < cmp_active), unsigned, registered.
  - cmp_active=0 gives raw_q always 0.
  - cmp_active > max carrier gives raw_q always 1.
- FSM states: IDLE, LOW, DEAD_R, HIGH, DEAD_F. Outputs are registered decodes of the next state:
  - HIGH: pwm_h=1, pwm_l=0.
  - LOW: pwm_h=0, pwm_l=1.
  - IDLE, DEAD_R, DEAD_F: both 0.
- IDLE:
  - With en=1 and raw_q=1: go to DEAD_R, cnt <= dt_rise-1 (or go directly to HIGH if dt_rise=0).
  - With en=1 and raw_q=0: go to DEAD_F, cnt <= dt_fall-1 (or go directly to LOW if dt_fall=0).
- LOW, raw_q=1: go to DEAD_R, cnt <= dt_rise-1 (or go to HIGH if dt_rise=0).
- HIGH, raw_q=0: go to DEAD_F, cnt <= dt_fall-1 (or go to LOW if dt_fall=0).
- DEAD_R:
  - raw_q=0 (abort): go to LOW. A pulse shorter than the dead time is suppressed; pwm_h never asserts.
  - cnt=0: go to HIGH.
  - Otherwise cnt <= cnt-1.
- DEAD_F: mirror of DEAD_R with raw_q=1 (abort, go to HIGH) and target LOW.
- Timing:
  - Both outputs are low for exactly dt cycles at each transition.
  - Latency from the carrier edge where the compare becomes true to pwm_h=1 is 2+dt_rise cycles; pwm_l follows the same rule with dt_fall.
- Invariant: pwm_h and pwm_l are never both 1, in any cycle, for any input sequence.
- en=0: synchronous. Next edge gives state=IDLE and both outputs 0, including mid-dead-time or mid-HIGH. The dead counter clears.
- dt_rise/dt_fall are sampled only when a DEAD state is entered. Changes while counting take effect at the next transition.
- Async reset mid-operation: outputs drop to 0 immediately, without waiting for a clock edge.

Test Plan:
- Reset and idle: assert rst_n=0 mid-HIGH, then release with en=0 -> pwm_h=pwm_l=0 immediately and stay 0; cmp_active=0.
- Zero dead time: load_mode=00, cmp_in=100, dt=0, en=1, carrier ramp 0..199 -> pwm_h=1 for exactly 100 cycles per period, pwm_l=1 for the other 100; pwm_h rises 2 cycles after carrier=0.
- Dead time: cmp_in=100, dt_rise=3, dt_fall=5 -> both low 3 cycles before each pwm_h rise and 5 cycles before each pwm_l rise; pwm_h high 97 cycles per period; never both high.
- Glitch suppression: dt_rise=4, force raw compare true for 2 cycles only -> pwm_h stays 0; pwm_l returns to 1 after 2 low cycles.
- Shadow load: load_mode=01, cmp_active=100, change cmp_in to 50 mid-period -> cmp_active stays 100 until the carrier_zero edge, then 50; load_ack high exactly 1 cycle after. With mode 11 and both pulses coincident -> a single load.
- Enable drop: deassert en during HIGH -> both outputs 0 next cycle; reassert en with raw_q=0 -> LOW after dt_fall cycles.

Source files
------------

// File: rtl/pwm_compare_deadtime.sv
// PWM compare stage with a shadow/active compare register pair and
// complementary high/low gate outputs with independent rise/fall dead time.
module pwm_compare_deadtime #(
    parameter int COUNT_WIDTH = 16,
    parameter int DT_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [COUNT_WIDTH-1:0] cmp_in,
    input  logic [COUNT_WIDTH-1:0] carrier,
    input  logic                   carrier_zero,
    input  logic                   carrier_top,
    input  logic [1:0]             load_mode,
    input  logic [DT_WIDTH-1:0]    dt_rise,
    input  logic [DT_WIDTH-1:0]    dt_fall,
    output logic                   pwm_h,
    output logic                   pwm_l,
    output logic [COUNT_WIDTH-1:0] cmp_active,
    output logic                   load_ack
);

    typedef enum logic [2:0] {IDLE, LOW, DEAD_R, HIGH, DEAD_F} state_t;

    state_t              state, state_nxt;
    logic [DT_WIDTH-1:0] cnt, cnt_nxt;
    logic                raw_q;
    logic                load_evt;

    // Compare update event; mode 11 ORs the pulses so coincident zero/top loads once
    always_comb begin
        case (load_mode)
            2'b00:   load_evt = 1'b1;
            2'b01:   load_evt = carrier_zero;
            2'b10:   load_evt = carrier_top;
            default: load_evt = carrier_zero | carrier_top;
        endcase
    end

    // Shadow-to-active compare transfer, independent of channel enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_active <= '0;
            load_ack   <= 1'b0;
        end else begin
            load_ack <= load_evt;
            if (load_evt)
                cmp_active <= cmp_in;
        end
    end

    // Registered raw compare; cmp_active=0 can never be exceeded, so raw stays low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            raw_q <= 1'b0;
        else
            raw_q <= (carrier < cmp_active);
    end

    // Next-state logic: dead-time entry samples dt_* only on the entering edge
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE, LOW: begin
                    if (raw_q) begin
                        if (dt_rise == '0) begin
                            state_nxt = HIGH;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = DEAD_R;
                            cnt_nxt   = dt_rise - DT_WIDTH'(1);
                        end
                    end else if (state == IDLE) begin
                        if (dt_fall == '0) begin
                            state_nxt = LOW;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = DEAD_F;
                            cnt_nxt   = dt_fall - DT_WIDTH'(1);
                        end
                    end
                end
                HIGH: begin
                    if (!raw_q) begin
                        if (dt_fall == '0) begin
                            state_nxt = LOW;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = DEAD_F;
                            cnt_nxt   = dt_fall - DT_WIDTH'(1);
                        end
                    end
                end
                DEAD_R: begin
                    // A compare pulse shorter than the dead time never reaches pwm_h
                    if (!raw_q) begin
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                    end else if (cnt == '0) begin
                        state_nxt = HIGH;
                    end else begin
                        cnt_nxt = cnt - DT_WIDTH'(1);
                    end
                end
                DEAD_F: begin
                    if (raw_q) begin
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                    end else if (cnt == '0) begin
                        state_nxt = LOW;
                    end else begin
                        cnt_nxt = cnt - DT_WIDTH'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State register with gate outputs decoded from the next state, so they
    // are glitch-free flops and can never be high together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pwm_h <= (state_nxt == HIGH);
            pwm_l <= (state_nxt == LOW);
        end
    end

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// Directed bench for pwm_compare_deadtime: table-driven compare loading,
// then carrier-ramp, glitch, enable-drop and async-reset sequences.
module tb_pwm_compare_deadtime;

    localparam int CW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [CW-1:0] cmp_in;
    logic [CW-1:0] carrier;
    logic          carrier_zero;
    logic          carrier_top;
    logic [1:0]    load_mode;
    logic [DW-1:0] dt_rise;
    logic [DW-1:0] dt_fall;
    logic          pwm_h;
    logic          pwm_l;
    logic [CW-1:0] cmp_active;
    logic          load_ack;

    int n_pass  = 0;
    int n_total = 0;
    logic prev_h = 1'b0;
    logic prev_l = 1'b0;

    typedef struct {
        logic [1:0]    mode;
        logic          zero;
        logic          top;
        logic [CW-1:0] cmp;
        logic [CW-1:0] exp_cmp;
        logic          exp_ack;
    } ld_vec_t;

    ld_vec_t ld_tab[12];

    pwm_compare_deadtime #(.COUNT_WIDTH(CW), .DT_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cmp_in(cmp_in), .carrier(carrier),
        .carrier_zero(carrier_zero), .carrier_top(carrier_top), .load_mode(load_mode),
        .dt_rise(dt_rise), .dt_fall(dt_fall), .pwm_h(pwm_h), .pwm_l(pwm_l),
        .cmp_active(cmp_active), .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 0..199 carrier period; returns high/low counts, overlap count and
    // the sample index of each output's rising edge (-1 if none)
    task automatic run_period(output int hc, output int lc, output int both,
                              output int hr, output int lr);
        hc = 0; lc = 0; both = 0; hr = -1; lr = -1;
        for (int i = 0; i < 200; i++) begin
            carrier      = CW'(i);
            carrier_zero = (i == 0);
            carrier_top  = (i == 199);
            step();
            if (pwm_h) hc++;
            if (pwm_l) lc++;
            if (pwm_h && pwm_l) both++;
            if (pwm_h && !prev_h && hr < 0) hr = i;
            if (pwm_l && !prev_l && lr < 0) lr = i;
            prev_h = pwm_h;
            prev_l = pwm_l;
        end
    endtask

    initial begin
        int hc, lc, both, hr, lr;
        logic [5:0] exp_l;

        ld_tab[0]  = '{2'b01, 1'b0, 1'b0, 16'd100, 16'd0,   1'b0};
        ld_tab[1]  = '{2'b01, 1'b1, 1'b0, 16'd100, 16'd100, 1'b1};
        ld_tab[2]  = '{2'b01, 1'b0, 1'b0, 16'd50,  16'd100, 1'b0};
        ld_tab[3]  = '{2'b01, 1'b0, 1'b1, 16'd50,  16'd100, 1'b0};
        ld_tab[4]  = '{2'b10, 1'b0, 1'b1, 16'd50,  16'd50,  1'b1};
        ld_tab[5]  = '{2'b10, 1'b1, 1'b0, 16'd70,  16'd50,  1'b0};
        ld_tab[6]  = '{2'b11, 1'b1, 1'b1, 16'd70,  16'd70,  1'b1};
        ld_tab[7]  = '{2'b11, 1'b0, 1'b0, 16'd80,  16'd70,  1'b0};
        ld_tab[8]  = '{2'b11, 1'b0, 1'b1, 16'd80,  16'd80,  1'b1};
        ld_tab[9]  = '{2'b00, 1'b0, 1'b0, 16'd90,  16'd90,  1'b1};
        ld_tab[10] = '{2'b00, 1'b0, 1'b0, 16'd91,  16'd91,  1'b1};
        ld_tab[11] = '{2'b01, 1'b0, 1'b0, 16'd92,  16'd91,  1'b0};

        rst_n = 1'b0; en = 1'b0; cmp_in = '0; carrier = '0;
        carrier_zero = 1'b0; carrier_top = 1'b0; load_mode = 2'b01;
        dt_rise = '0; dt_fall = '0;

        // Reset state
        #12;
        chk("reset pwm_h", pwm_h, 0);
        chk("reset pwm_l", pwm_l, 0);
        chk("reset cmp_active", cmp_active, 0);
        chk("reset load_ack", load_ack, 0);
        #1 rst_n = 1'b1;
        step();

        // Compare loading table (en=0, loading still works)
        for (int k = 0; k < 12; k++) begin
            load_mode    = ld_tab[k].mode;
            carrier_zero = ld_tab[k].zero;
            carrier_top  = ld_tab[k].top;
            cmp_in       = ld_tab[k].cmp;
            step();
            chk($sformatf("load[%0d] cmp_active", k), cmp_active, ld_tab[k].exp_cmp);
            chk($sformatf("load[%0d] load_ack", k), load_ack, ld_tab[k].exp_ack);
            chk($sformatf("load[%0d] outputs idle", k), {pwm_h, pwm_l}, 0);
        end
        carrier_zero = 1'b0; carrier_top = 1'b0;

        // Zero dead time, cmp=100 over a 200-count ramp
        load_mode = 2'b00; cmp_in = 16'd100; dt_rise = '0; dt_fall = '0; en = 1'b1;
        run_period(hc, lc, both, hr, lr);
        run_period(hc, lc, both, hr, lr);
        chk("dt0 high count", hc, 100);
        chk("dt0 low count", lc, 100);
        chk("dt0 overlap", both, 0);
        chk("dt0 pwm_h rise idx", hr, 1);
        chk("dt0 pwm_l rise idx", lr, 101);

        // Dead time rise=3, fall=5
        dt_rise = 8'd3; dt_fall = 8'd5;
        run_period(hc, lc, both, hr, lr);
        run_period(hc, lc, both, hr, lr);
        chk("dt35 high count", hc, 97);
        chk("dt35 low count", lc, 95);
        chk("dt35 overlap", both, 0);
        chk("dt35 pwm_h rise idx", hr, 4);
        chk("dt35 pwm_l rise idx", lr, 106);

        // Glitch suppression: compare true for only 2 cycles with dt_rise=4
        cmp_in = 16'd10; dt_rise = 8'd4; dt_fall = 8'd5;
        carrier = 16'd50; carrier_zero = 1'b0; carrier_top = 1'b0;
        repeat (10) step();
        chk("glitch settled low", {pwm_h, pwm_l}, 1);
        exp_l = 6'b111001;
        for (int k = 0; k < 6; k++) begin
            carrier = (k < 2) ? 16'd5 : 16'd50;
            step();
            chk($sformatf("glitch[%0d] pwm_h", k), pwm_h, 0);
            chk($sformatf("glitch[%0d] pwm_l", k), pwm_l, exp_l[k]);
        end

        // Enable drop during HIGH, then re-enable with compare false
        dt_rise = '0; dt_fall = 8'd3; carrier = 16'd5;
        repeat (5) step();
        chk("en pre-drop pwm_h", pwm_h, 1);
        en = 1'b0;
        step();
        chk("en drop outputs", {pwm_h, pwm_l}, 0);
        carrier = 16'd50;
        repeat (3) step();
        chk("en low outputs held", {pwm_h, pwm_l}, 0);
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("reenable[%0d] pwm_l", k), pwm_l, (k == 3) ? 1 : 0);
            chk($sformatf("reenable[%0d] pwm_h", k), pwm_h, 0);
        end

        // Async reset mid-HIGH: outputs drop without a clock edge
        carrier = 16'd5;
        repeat (4) step();
        chk("pre-reset pwm_h", pwm_h, 1);
        load_mode = 2'b01; carrier_zero = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async reset pwm_h", pwm_h, 0);
        chk("async reset pwm_l", pwm_l, 0);
        chk("async reset cmp_active", cmp_active, 0);
        en = 1'b0;
        #3 rst_n = 1'b1;
        repeat (3) step();
        chk("post-reset outputs", {pwm_h, pwm_l}, 0);
        chk("post-reset cmp_active", cmp_active, 0);
        chk("post-reset load_ack", load_ack, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
